// File: rtl/rf_spi_rx_packer.sv
// SDO capture and word packer for the RF transceiver: skips a header, packs bits MSB/LSB-first
// into WORD_W-bit words and buffers them in a first-word fall-through FIFO.
module rf_spi_rx_packer #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SKIP_W = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cs_n_i,
    input  logic                       bit_strb_i,
    input  logic                       sdo_i,
    input  logic [SKIP_W-1:0]          skip_bits_i,
    input  logic                       msb_first_i,
    input  logic                       flush_partial_i,
    input  logic                       flush_i,
    input  logic                       ovf_clr_i,
    output logic [WORD_W-1:0]          rx_data_o,
    output logic                       rx_valid_o,
    input  logic                       rx_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic                       frame_done_o
);

    localparam int unsigned BitCntW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CountW  = $clog2(DEPTH + 1);

    localparam logic [BitCntW:0]   WordWL  = (BitCntW + 1)'(WORD_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(WORD_W - 1);

    typedef enum logic [1:0] {StIdle, StSkip, StShift} state_e;

    state_e              state_q, state_d;
    logic                cs_n_q;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic                msb_q, msb_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic                frame_done_q, frame_done_d;

    logic                frame_start, frame_end, strb_ok;
    logic [WORD_W-1:0]   sh_next, partial_word;
    logic [BitCntW:0]    pad_amt;
    logic                push;
    logic [WORD_W-1:0]   push_data;

    assign frame_start = cs_n_q & ~cs_n_i;
    assign frame_end   = ~cs_n_q & cs_n_i;
    assign strb_ok     = bit_strb_i & ~cs_n_i;
    assign sh_next     = msb_q ? {sh_q[WORD_W-2:0], sdo_i} : {sdo_i, sh_q[WORD_W-1:1]};

    // Shifting the captured bits into place also zero-fills the missing positions.
    assign pad_amt      = WordWL - {1'b0, bit_cnt_q};
    assign partial_word = msb_q ? (sh_q << pad_amt) : (sh_q >> pad_amt);

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        msb_d        = msb_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        push_data    = '0;
        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    skip_d    = skip_bits_i;
                    msb_d     = msb_first_i;
                    bit_cnt_d = '0;
                    sh_d      = '0;
                    state_d   = (skip_bits_i != '0) ? StSkip : StShift;
                end
            end
            StSkip: begin
                if (frame_end) begin
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                end else if (strb_ok) begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) state_d = StShift;
                end
            end
            StShift: begin
                if (frame_end) begin
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                    if ((bit_cnt_q != '0) && flush_partial_i) begin
                        push      = 1'b1;
                        push_data = partial_word;
                    end
                end else if (strb_ok) begin
                    sh_d = sh_next;
                    if (bit_cnt_q == LastBit) begin
                        push      = 1'b1;
                        push_data = sh_next;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d      = StIdle;
            frame_done_d = 1'b0;
            push         = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cs_n_q       <= 1'b1;
            skip_q       <= '0;
            msb_q        <= 1'b0;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_n_q       <= cs_n_i;
            skip_q       <= skip_d;
            msb_q        <= msb_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_q         <= sh_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FIFO
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop, wr_en, drop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CountW'(DEPTH));
    assign rx_valid_o = ~empty_o;
    assign rx_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign frame_done_o = frame_done_q;

    assign pop   = rx_valid_o & rx_ready_i;
    assign wr_en = push & (~full_o | pop);
    assign drop  = push & full_o & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CountW'(wr_en) - CountW'(pop);
            // A new drop outranks a simultaneous clear.
            if (drop)           overflow_d = 1'b1;
            else if (ovf_clr_i) overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_rf_spi_rx_packer.sv
// Directed bench for rf_spi_rx_packer (WORD_W=8, DEPTH=16); inputs change and outputs are
// sampled on the falling clock edge.
module tb_rf_spi_rx_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1, bit_strb = 1'b0, sdo = 1'b0;
    logic [4:0] skip_bits = '0;
    logic       msb_first = 1'b1, flush_partial = 1'b0, flush = 1'b0, ovf_clr = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, full, empty, overflow, frame_done;
    logic [4:0] count;

    int nvec = 0;
    int nerr = 0;
    int fd_cnt = 0;

    rf_spi_rx_packer #(.WORD_W(8), .DEPTH(16), .SKIP_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cs_n_i(cs_n), .bit_strb_i(bit_strb), .sdo_i(sdo),
        .skip_bits_i(skip_bits), .msb_first_i(msb_first), .flush_partial_i(flush_partial),
        .flush_i(flush), .ovf_clr_i(ovf_clr), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .count_o(count), .full_o(full), .empty_o(empty),
        .overflow_o(overflow), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

    task automatic start_frame(input logic [4:0] skip, input logic msb, input logic strb_start);
        @(negedge clk);
        skip_bits = skip; msb_first = msb; cs_n = 1'b0;
        if (strb_start) begin bit_strb = 1'b1; sdo = 1'b1; end
        @(negedge clk);
        bit_strb = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk); cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic pop);
        @(negedge clk);
        sdo = b; bit_strb = 1'b1;
        if (pop) rx_ready = 1'b1;
        @(negedge clk);
        bit_strb = 1'b0;
        if (pop) rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic msb, input logic pop_last);
        for (int i = 0; i < 8; i++) send_bit(msb ? w[7-i] : w[i], pop_last && (i == 7));
    endtask

    task automatic pop_word();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
        nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full got %b want 0", full); end
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty got %b want 1", empty); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow got %b want 0", overflow); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    endtask

    task automatic test_msb_basic();
        logic [7:0] words [2];
        int fd0;
        words[0] = 8'hA5; words[1] = 8'h3C;
        fd0 = fd_cnt;
        rx_ready = 1'b1;
        start_frame(5'd0, 1'b1, 1'b0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 7; i++) send_bit(words[w][7-i], 1'b0);
            nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid w%0d got %b want 0", w, rx_valid); end
            send_bit(words[w][0], 1'b0);
            nvec++; if (rx_valid !== 1'b1 || rx_data !== words[w])
                begin nerr++; $display("FAIL basic_word w%0d got v=%b %h want v=1 %h", w, rx_valid, rx_data, words[w]); end
        end
        end_frame();
        rx_ready = 1'b0;
        nvec++; if (fd_cnt - fd0 != 1) begin nerr++; $display("FAIL basic_frame_done got %0d pulses want 1", fd_cnt - fd0); end
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL basic_empty got %b want 1", empty); end
    endtask

    task automatic test_skip_lsb();
        start_frame(5'd8, 1'b0, 1'b1);   // strobe in the frame-start cycle must not count
        send_word(8'h83, 1'b1, 1'b0);
        send_word(8'h01, 1'b0, 1'b0);
        end_frame();
        nvec++; if (count !== 5'd1) begin nerr++; $display("FAIL skip_count got %0d want 1", count); end
        nvec++; if (rx_data !== 8'h01) begin nerr++; $display("FAIL skip_data got %h want 01", rx_data); end
        pop_word();
    endtask

    task automatic test_partial();
        logic [10:0] bits;
        bits = 11'b1010_1100_101;
        for (int fp = 1; fp >= 0; fp--) begin
            flush_partial = fp[0];
            start_frame(5'd0, 1'b1, 1'b0);
            for (int i = 10; i >= 0; i--) send_bit(bits[i], 1'b0);
            end_frame();
            nvec++; if (count !== ((fp == 1) ? 5'd2 : 5'd1))
                begin nerr++; $display("FAIL partial_count fp=%0d got %0d want %0d", fp, count, fp + 1); end
            nvec++; if (rx_data !== 8'hAC) begin nerr++; $display("FAIL partial_first fp=%0d got %h want ac", fp, rx_data); end
            pop_word();
            if (fp == 1) begin
                nvec++; if (rx_data !== 8'hA0) begin nerr++; $display("FAIL partial_msb_pad got %h want a0", rx_data); end
                pop_word();
            end
            nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL partial_empty fp=%0d got %b want 1", fp, empty); end
        end
        flush_partial = 1'b1;
        start_frame(5'd0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        end_frame();
        nvec++; if (rx_data !== 8'h05) begin nerr++; $display("FAIL partial_lsb_pad got %h want 05", rx_data); end
        pop_word();
        flush_partial = 1'b0;
    endtask

    task automatic test_overflow();
        start_frame(5'd0, 1'b1, 1'b0);
        for (int k = 0; k < 17; k++) send_word(8'(k * 37 + 5), 1'b1, 1'b0);
        nvec++; if (full !== 1'b1) begin nerr++; $display("FAIL ovf_full got %b want 1", full); end
        nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL ovf_count got %0d want 16", count); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag got %b want 1", overflow); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clr got %b want 0", overflow); end
        end_frame();
        for (int k = 0; k < 16; k++) begin
            nvec++; if (rx_data !== 8'(k * 37 + 5))
                begin nerr++; $display("FAIL ovf_order k%0d got %h want %h", k, rx_data, 8'(k * 37 + 5)); end
            pop_word();
        end
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL ovf_drained got %b want 1", empty); end
    endtask

    task automatic test_full_push_pop();
        start_frame(5'd0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) send_word(8'(k * 13 + 1), 1'b1, 1'b0);
        for (int k = 16; k < 40; k++) send_word(8'(k * 13 + 1), 1'b1, 1'b1);
        nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL pp_count got %0d want 16", count); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL pp_overflow got %b want 0", overflow); end
        end_frame();
        for (int k = 24; k < 40; k++) begin
            nvec++; if (rx_data !== 8'(k * 13 + 1))
                begin nerr++; $display("FAIL pp_order k%0d got %h want %h", k, rx_data, 8'(k * 13 + 1)); end
            pop_word();
        end
    endtask

    task automatic test_flush();
        int fd0;
        fd0 = fd_cnt;
        start_frame(5'd0, 1'b1, 1'b0);
        send_word(8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL flush_count got %0d want 0", count); end
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        send_word(8'hFF, 1'b1, 1'b0);
        end_frame();
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL flush_ignored got %0d want 0", count); end
        nvec++; if (fd_cnt != fd0) begin nerr++; $display("FAIL flush_no_done got %0d pulses want 0", fd_cnt - fd0); end
        start_frame(5'd0, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b0);
        end_frame();
        nvec++; if (rx_data !== 8'h5A || count !== 5'd1)
            begin nerr++; $display("FAIL flush_next got %h n=%0d want 5a n=1", rx_data, count); end
        pop_word();
    endtask

    task automatic test_reset_mid();
        start_frame(5'd0, 1'b1, 1'b0);
        send_word(8'h77, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        nvec++; if (rx_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || rx_data !== 8'h00)
            begin nerr++; $display("FAIL rst_mid got v=%b n=%0d e=%b d=%h want 0/0/1/00", rx_valid, count, empty, rx_data); end
        @(negedge clk); cs_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        start_frame(5'd0, 1'b1, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0);
        end_frame();
        nvec++; if (rx_data !== 8'h3C || count !== 5'd1)
            begin nerr++; $display("FAIL rst_after got %h n=%0d want 3c n=1", rx_data, count); end
        pop_word();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_msb_basic();
        test_skip_lsb();
        test_partial();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
